// File: rtl/add8_share_arb.sv
// add8_share_arb: round-robin sharing of one external 8-bit adder among
// NREQ requesters, with a valid/ready response channel and a saturating
// completed-operation counter.
module add8_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic [7:0]        add_a,
  output logic [7:0]        add_b,
  input  logic [8:0]        add_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [8:0]        rsp_sum,
  output logic [CNTW-1:0]   op_count
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = DW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IDW-1:0]  rr_ptr_q;
  logic [DW-1:0]   op_a_q;
  logic [DW-1:0]   op_b_q;
  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant_oh;
  logic [DW-1:0]   sel_a;
  logic [DW-1:0]   sel_b;
  logic            rsp_fire;
  logic [IDW-1:0]  rr_next;

  // Round-robin pick: first pass covers indices at/after rr_ptr, second pass wraps.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_any && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
        grant_any   = 1'b1;
        grant_idx   = IDW'(i);
        grant_oh[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any   = 1'b1;
        grant_idx   = IDW'(i);
        grant_oh[i] = 1'b1;
      end
    end
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_oh[i]) begin
        sel_a = req_a[DW*i +: DW];
        sel_b = req_b[DW*i +: DW];
      end
    end
  end

  // Next-state logic and combinational handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (rst_n) begin
          req_ready = grant_oh;
        end
        if (grant_any) begin
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_fire = (state_q == RESP) && rsp_valid && rsp_ready;
  assign rr_next  = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
  assign add_a    = op_a_q;
  assign add_b    = op_b_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on grant, result capture after the adder cycle, pointer advance on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a_q    <= '0;
      op_b_q    <= '0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_valid <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      if (state_q == IDLE && grant_any) begin
        op_a_q <= sel_a;
        op_b_q <= sel_b;
        rsp_id <= grant_idx;
      end
      if (state_q == EXEC) begin
        rsp_sum   <= SW'(add_o);
        rsp_valid <= 1'b1;
      end
      if (rsp_fire) begin
        rsp_valid <= 1'b0;
        rr_ptr_q  <= rr_next;
      end
    end
  end

  // Saturating count of consumed responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (rsp_fire && (op_count != '1)) begin
      op_count <= op_count + CNTW'(1);
    end
  end

  // Requesters must keep operands stable while waiting for a grant.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_chk
    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[gi] && !req_ready[gi]) |=>
        (!req_valid[gi] || ($stable(req_a[DW*gi +: DW]) && $stable(req_b[DW*gi +: DW]))));
  end

  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule
